// File: rtl/fifo_counted.sv
// Single-clock FIFO with arbitrary depth, first-word-fall-through output,
// occupancy count, programmable almost-full/empty and sticky error flags.
module fifo_counted #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  parameter  int AF_LEVEL   = 12,
  parameter  int AE_LEVEL   = 2,
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1),
  localparam int PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  ENABLE,
  input  logic                  FLUSH,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  PUSH,
  input  logic                  POP,
  input  logic                  CLR_ERR,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [CNT_WIDTH-1:0]  COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_LEVEL);
  localparam logic [PTR_WIDTH-1:0] LAST_C  = PTR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic full_q, full_d, empty_q, empty_d, af_q, af_d, ae_q, ae_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic active, accept_push, accept_pop, ovf_set, unf_set;

  // Explicit wrap so any depth works, not just powers of two.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  always_comb begin
    active      = ENABLE && !FLUSH;
    accept_pop  = POP && !empty_q;
    accept_push = PUSH && (!full_q || POP);
    ovf_set     = active && PUSH && full_q && !POP;
    unf_set     = active && POP && empty_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (ENABLE && FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (active) begin
      if (accept_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (accept_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_WIDTH'(accept_push) - CNT_WIDTH'(accept_pop);
    end

    // Flags follow the next count so they line up with COUNT.
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);

    // A new error in the same cycle as CLR_ERR wins.
    ovf_d = (ovf_q && !CLR_ERR) || ovf_set;
    unf_d = (unf_q && !CLR_ERR) || unf_set;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage has no reset so it can map onto RAM.
  always_ff @(posedge CLK) begin
    if (active && accept_push) mem[wr_ptr_q] <= DATA_IN;
  end

  assign DATA_OUT     = empty_q ? '0 : mem[rd_ptr_q];
  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = af_q;
  assign ALMOST_EMPTY = ae_q;
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule

// File: doc/fifo_counted.md
Name: fifo_counted

Overview:
Parametrised synchronous FIFO; next generation of the team's single-clock FIFO. Adds:
- arbitrary (non-power-of-two) depth
- first-word-fall-through output
- occupancy count
- programmable almost-full/almost-empty flags
- sticky overflow/underflow error flags

Sits between stream producers/consumers, e.g. the UART RX/TX paths and the command parser.

Parameters:
DATA_WIDTH, 8, width of DATA_IN/DATA_OUT
DEPTH, 16, number of entries; any integer >= 2
AF_LEVEL, 12, ALMOST_FULL asserted when COUNT >= AF_LEVEL; legal range 1..DEPTH
AE_LEVEL, 2, ALMOST_EMPTY asserted when COUNT <= AE_LEVEL; legal range 0..DEPTH-1
CNT_WIDTH, $clog2(DEPTH+1), derived width of COUNT; never overridden
PTR_WIDTH, $clog2(DEPTH), derived pointer width; never overridden

Ports:
CLK  in  1  clock for all logic
RESET_N  in  1  asynchronous active-low reset
ENABLE  in  1  block active when 1; when 0, PUSH/POP/FLUSH ignored, all state held
FLUSH  in  1  empties FIFO in one cycle
DATA_IN  in  DATA_WIDTH  write data, captured on accepted push
PUSH  in  1  write request
POP  in  1  read request; consumes the current DATA_OUT word
CLR_ERR  in  1  clears OVERFLOW/UNDERFLOW
DATA_OUT  out  DATA_WIDTH  head-of-FIFO word (FWFT); 0 when EMPTY
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  COUNT == 0
ALMOST_FULL  out  1  COUNT >= AF_LEVEL
ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL
COUNT  out  CNT_WIDTH  current occupancy, 0..DEPTH
OVERFLOW  out  1  sticky: a push was rejected
UNDERFLOW  out  1  sticky: a pop was rejected

Behaviour:
Reset:
- RESET_N low, asynchronous: wr_ptr=0, rd_ptr=0, COUNT=0, EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0 (AF_LEVEL>=1), OVERFLOW=0, UNDERFLOW=0, DATA_OUT=0.
- Memory array is not reset (RAM inference).
- Reset mid-operation discards all contents immediately; deassertion takes effect at the next CLK edge.

Accept rules, evaluated each rising edge with ENABLE=1 and FLUSH=0:
- accept_pop = POP && !EMPTY
- accept_push = PUSH && (!FULL || POP)
- Push while FULL with simultaneous POP: both accepted; COUNT unchanged.
- Pop while EMPTY with simultaneous PUSH: push accepted, pop rejected; UNDERFLOW set; COUNT becomes 1.

Datapath and pointers:
- Accepted push writes memory[wr_ptr] <= DATA_IN.
- Pointers increment by 1 and wrap from DEPTH-1 to 0; no power-of-two assumption.
- COUNT next = COUNT + accept_push - accept_pop.
- FULL, EMPTY, ALMOST_* are registered and derived from next COUNT, so they are valid in the same cycle COUNT updates.

Latency:
- FWFT: a word pushed into an empty FIFO appears on DATA_OUT, with EMPTY=0, the cycle after the push edge.
- DATA_OUT = memory[rd_ptr] when !EMPTY, else 0. The combinational mux is from registered state only.

Errors:
- OVERFLOW set on PUSH && FULL && !POP.
- UNDERFLOW set on POP && EMPTY.
- Both flags are sticky until CLR_ERR. If a set and CLR_ERR occur in the same cycle, set wins.
- Errors are evaluated only when ENABLE=1 and FLUSH=0.

FLUSH (ENABLE=1):
- Pointers=0, COUNT=0, flags recomputed (EMPTY=1).
- FLUSH has priority over PUSH/POP in the same cycle; those requests are dropped without raising error flags.
- Memory is not cleared. Error flags are not cleared by FLUSH.

ENABLE=0:
- Full hold of all registers and outputs. DATA_OUT continues to show the head word.
- CLR_ERR still honoured.

Test Plan:
- Reset, then push 0x11,0x22,0x33 (DEPTH=16) -> DATA_OUT=0x11 one cycle after first push; COUNT=3; EMPTY=0; ALMOST_EMPTY=0; pops return 0x11,0x22,0x33; then EMPTY=1, DATA_OUT=0.
- DEPTH=5, AF_LEVEL=4: push 5 words -> ALMOST_FULL at COUNT=4, FULL at 5; 6th push alone -> rejected, OVERFLOW=1, COUNT=5; push+pop while full -> COUNT stays 5, order preserved across pointer wrap at 4->0.
- Pop on empty with no push -> UNDERFLOW=1, COUNT=0; then push+pop same cycle while empty -> COUNT=1, UNDERFLOW still 1; CLR_ERR pulse -> UNDERFLOW=0.
- With COUNT=7, assert FLUSH together with PUSH and POP -> next cycle COUNT=0, EMPTY=1, no error flags set; next push 0xA5 -> DATA_OUT=0xA5.
- With COUNT=3, drop ENABLE and toggle PUSH/POP for 10 cycles -> COUNT=3, DATA_OUT unchanged; re-enable and pop -> correct sequence.
- Assert RESET_N low asynchronously between edges with COUNT=9 -> outputs go to reset values before the next CLK edge; contents gone after release.
